// File: rtl/mem_byte_master.sv
// rtl/mem_byte_master.sv - 24-bit load/store split into three big-endian byte transactions
module mem_byte_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [23:0] Address,
    input  logic [23:0] WriteData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [23:0] ReadData,
    output logic        MemReq,
    output logic        MemWe,
    output logic [23:0] MemAddr,
    output logic [7:0]  MemWData,
    input  logic [7:0]  MemRData,
    input  logic        MemAck
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FINISH
    } state_t;

    // Last no-ack cycle count before the request is abandoned.
    localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [23:0] addr_q;
    logic [23:0] wdata_q;
    logic [23:0] asm_q;
    logic        op_store;
    logic [1:0]  idx;
    logic [1:0]  next_idx;
    logic [7:0]  tcnt;

    // Big-endian lane select: byte 0 is the most significant.
    function automatic logic [7:0] byte_sel(input logic [23:0] d, input logic [1:0] sel);
        case (sel)
            2'd0:    byte_sel = d[23:16];
            2'd1:    byte_sel = d[15:8];
            default: byte_sel = d[7:0];
        endcase
    endfunction

    // Index of the byte presented after the current one is acknowledged.
    always_comb begin
        next_idx = idx + 2'd1;
    end

    // Transaction sequencer; all outputs are registered here.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            asm_q    <= '0;
            op_store <= 1'b0;
            idx      <= '0;
            tcnt     <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Error    <= 1'b0;
            ReadData <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
        end else begin
            Done  <= 1'b0;
            Error <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && MemRead && MemWrite) begin
                        Error <= 1'b1;
                    end else if (Start && (MemRead ^ MemWrite)) begin
                        addr_q   <= Address;
                        wdata_q  <= WriteData;
                        op_store <= MemWrite;
                        idx      <= 2'd0;
                        tcnt     <= '0;
                        asm_q    <= '0;
                        Busy     <= 1'b1;
                        MemReq   <= 1'b1;
                        MemWe    <= MemWrite;
                        MemAddr  <= Address;
                        MemWData <= WriteData[23:16];
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (MemAck) begin
                        tcnt <= '0;
                        if (!op_store) begin
                            case (idx)
                                2'd0:    asm_q[23:16] <= MemRData;
                                2'd1:    asm_q[15:8]  <= MemRData;
                                default: asm_q[7:0]   <= MemRData;
                            endcase
                        end
                        if (idx == 2'd2) begin
                            MemReq <= 1'b0;
                            MemWe  <= 1'b0;
                            Busy   <= 1'b0;
                            Done   <= 1'b1;
                            if (!op_store) begin
                                ReadData <= {asm_q[23:8], MemRData};
                            end
                            state <= FINISH;
                        end else begin
                            idx      <= next_idx;
                            MemAddr  <= addr_q + {22'd0, next_idx};
                            MemWData <= byte_sel(wdata_q, next_idx);
                        end
                    end else if (tcnt == TLAST) begin
                        MemReq <= 1'b0;
                        MemWe  <= 1'b0;
                        Busy   <= 1'b0;
                        Error  <= 1'b1;
                        tcnt   <= '0;
                        state  <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_master.sv
// tb/tb_mem_byte_master.sv - directed and randomized bench for mem_byte_master
module tb_mem_byte_master;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic        MemRead;
    logic        MemWrite;
    logic [23:0] Address;
    logic [23:0] WriteData;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [23:0] ReadData;
    logic        MemReq;
    logic        MemWe;
    logic [23:0] MemAddr;
    logic [7:0]  MemWData;
    logic [7:0]  MemRData;
    logic        MemAck;

    always #5 Clock = ~Clock;

    mem_byte_master #(.TIMEOUT_CYCLES(4)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Address  (Address),
        .WriteData(WriteData),
        .Busy     (Busy),
        .Done     (Done),
        .Error    (Error),
        .ReadData (ReadData),
        .MemReq   (MemReq),
        .MemWe    (MemWe),
        .MemAddr  (MemAddr),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .MemAck   (MemAck)
    );

    int          ntests = 0;
    int          nfail  = 0;
    logic [7:0]  mem [int];
    logic [23:0] exp_rd;

    // Byte memory model; untouched locations hold an address-derived pattern.
    function automatic logic [7:0] mem_rd(input logic [23:0] a);
        if (mem.exists(int'({8'd0, a}))) return mem[int'({8'd0, a})];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One legal request; the bench plays memory with the given ack delays.
    task automatic do_op(input logic st, input logic [23:0] a, input logic [23:0] wd,
                         input int d0, input int d1, input int d2, input logic start_fin);
        int          dl[3];
        logic [23:0] ba;
        logic [23:0] asmb;
        logic [7:0]  wb;
        dl[0] = d0; dl[1] = d1; dl[2] = d2;
        asmb = '0;
        Start = 1'b1; MemRead = ~st; MemWrite = st; Address = a; WriteData = wd; MemAck = 1'b0;
        @(negedge Clock);
        for (int b = 0; b < 3; b++) begin
            ba = a + 24'(b);
            wb = 8'(wd >> (16 - 8 * b));
            for (int w = 0; w <= dl[b]; w++) begin
                chk("busy", {23'd0, Busy}, 24'd1);
                chk("memreq", {23'd0, MemReq}, 24'd1);
                chk("memaddr", MemAddr, ba);
                chk("memwe", {23'd0, MemWe}, {23'd0, st});
                if (st) chk("memwdata", {16'd0, MemWData}, {16'd0, wb});
                Start = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
                Address = 24'($urandom); WriteData = 24'($urandom);
                if (w == dl[b]) begin
                    MemAck = 1'b1;
                    MemRData = mem_rd(ba);
                    if (st) mem[int'({8'd0, ba})] = wb;
                    else asmb = asmb | (24'(mem_rd(ba)) << (16 - 8 * b));
                end else begin
                    MemAck = 1'b0;
                    MemRData = 8'($urandom);
                end
                @(negedge Clock);
            end
        end
        MemAck = 1'b0;
        Start = start_fin; MemRead = 1'b1; MemWrite = 1'b0; Address = 24'($urandom);
        if (!st) exp_rd = asmb;
        chk("done", {23'd0, Done}, 24'd1);
        chk("busy_fin", {23'd0, Busy}, 24'd0);
        chk("memreq_fin", {23'd0, MemReq}, 24'd0);
        chk("readdata", ReadData, exp_rd);
        @(negedge Clock);
        Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        chk("done_pulse", {23'd0, Done}, 24'd0);
        chk("busy_after", {23'd0, Busy}, 24'd0);
        chk("memreq_after", {23'd0, MemReq}, 24'd0);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; WriteData = '0; MemRData = '0; MemAck = 1'b0;
        exp_rd = '0;
        repeat (2) @(negedge Clock);
        chk("rst_busy", {23'd0, Busy}, 24'd0);
        chk("rst_done", {23'd0, Done}, 24'd0);
        chk("rst_error", {23'd0, Error}, 24'd0);
        chk("rst_readdata", ReadData, 24'd0);
        chk("rst_memreq", {23'd0, MemReq}, 24'd0);
        chk("rst_memwe", {23'd0, MemWe}, 24'd0);
        chk("rst_memaddr", MemAddr, 24'd0);
        chk("rst_memwdata", {16'd0, MemWData}, 24'd0);
        Reset = 1'b0;

        // Stray ack with no request outstanding
        MemAck = 1'b1;
        @(negedge Clock);
        MemAck = 1'b0;
        chk("stray_ack_req", {23'd0, MemReq}, 24'd0);
        chk("stray_ack_busy", {23'd0, Busy}, 24'd0);

        // Load, ack tied high
        mem[32'h10] = 8'hAB; mem[32'h11] = 8'hCD; mem[32'h12] = 8'hEF;
        do_op(1'b0, 24'h000010, 24'h0, 0, 0, 0, 1'b0);
        chk("load_abcdef", ReadData, 24'hABCDEF);

        // Store with two-cycle ack delay, Start during FINISH
        do_op(1'b1, 24'h000020, 24'h123456, 2, 2, 2, 1'b1);
        chk("store_keeps_rd", ReadData, 24'hABCDEF);

        // Illegal request
        Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b1;
        @(negedge Clock);
        Start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        chk("illegal_error", {23'd0, Error}, 24'd1);
        chk("illegal_busy", {23'd0, Busy}, 24'd0);
        chk("illegal_req", {23'd0, MemReq}, 24'd0);
        @(negedge Clock);
        chk("illegal_error_pulse", {23'd0, Error}, 24'd0);
        chk("illegal_req2", {23'd0, MemReq}, 24'd0);

        // Timeout with no ack
        Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Address = 24'h000040; MemAck = 1'b0;
        @(negedge Clock);
        Start = 1'b0; MemRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_memreq", {23'd0, MemReq}, 24'd1);
            chk("to_noerr", {23'd0, Error}, 24'd0);
            @(negedge Clock);
        end
        chk("to_memreq_drop", {23'd0, MemReq}, 24'd0);
        chk("to_error", {23'd0, Error}, 24'd1);
        chk("to_busy", {23'd0, Busy}, 24'd0);
        chk("to_readdata", ReadData, 24'hABCDEF);
        @(negedge Clock);
        chk("to_error_pulse", {23'd0, Error}, 24'd0);

        // Address wrap
        do_op(1'b0, 24'hFFFFFE, 24'h0, 0, 1, 0, 1'b0);

        // Reset after first byte of a load
        Start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Address = 24'h000050;
        @(negedge Clock);
        Start = 1'b0; MemRead = 1'b0;
        MemAck = 1'b1; MemRData = 8'h77;
        @(negedge Clock);
        MemAck = 1'b0; Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        exp_rd = '0;
        chk("rst_mid_req", {23'd0, MemReq}, 24'd0);
        chk("rst_mid_busy", {23'd0, Busy}, 24'd0);
        chk("rst_mid_rd", ReadData, 24'd0);
        do_op(1'b0, 24'h000010, 24'h0, 1, 0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 25; n++) begin
            do_op(1'($urandom), 24'($urandom), 24'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_byte_master.md
Name: mem_byte_master

Overview:
- CPU-side load/store initiator that drives a byte-wide, big-endian data memory port.
- Accepts one 24-bit load or store from the datapath and splits it into three sequential byte transactions over a request/acknowledge memory interface.
- For loads, assembles the three bytes and returns the 24-bit word.
- Sits between the CPU datapath (MEM stage) and the byte-addressed data memory.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for MemAck on one byte before aborting; range 1..255.

Ports:
- Clock  input  1  system clock; all logic on posedge
- Reset  input  1  synchronous, active-high reset
- Start  input  1  one-cycle request strobe from CPU; sampled only when Busy=0
- MemRead  input  1  request is a load
- MemWrite  input  1  request is a store
- Address  input  24  byte address of the word's MSB
- WriteData  input  24  store data
- Busy  output  1  transaction in progress
- Done  output  1  one-cycle pulse on successful completion
- Error  output  1  one-cycle pulse on illegal request or timeout
- ReadData  output  24  assembled load data; held until next accepted load
- MemReq  output  1  byte request to memory
- MemWe  output  1  byte write enable (valid with MemReq)
- MemAddr  output  24  byte address
- MemWData  output  8  byte write data
- MemRData  input  8  byte read data (valid with MemAck)
- MemAck  input  1  memory accepts/completes current byte

Behaviour:
- Reset values: Busy=0, Done=0, Error=0, ReadData=0, MemReq=0, MemWe=0, MemAddr=0, MemWData=0; state IDLE.
- Reset asserted mid-transaction: next edge forces IDLE, MemReq drops, partial ReadData is discarded and cleared to 0.
- States: IDLE, REQ, FINISH.
- IDLE:
  - Start=1 with exactly one of MemRead/MemWrite set: latch Address, WriteData and op; byte index=0; go to REQ.
  - Start=1 with both set: Error=1 for one cycle; stay in IDLE; no memory activity.
  - Start=1 with neither set: ignored.
- REQ (Busy=1):
  - Drive MemReq=1, MemAddr=latched Address+index (modulo 2^24, wraps 0xFFFFFF->0x000000), MemWe=op is store.
  - MemWData: index0=[23:16], index1=[15:8], index2=[7:0] (big-endian).
  - MemReq and outputs are held stable until MemAck.
  - On the MemAck edge: for loads, capture MemRData into the same byte lane order; increment index; clear the timeout counter.
  - If index was 2: go to FINISH with MemReq=0.
  - Otherwise stay in REQ with the next address presented on the following cycle. MemReq stays high continuously across bytes.
- Timeout: a counter increments each REQ cycle without MemAck. On reaching TIMEOUT_CYCLES: drop MemReq, pulse Error, return to IDLE. ReadData is not updated.
- FINISH: Done=1 for exactly one cycle. ReadData is updated from the assembly register in the same cycle Done rises (loads only; stores leave ReadData unchanged). Busy=0 in FINISH; return to IDLE.
- Latency: with MemAck tied high, Start at cycle 0 gives MemReq in cycles 1-3 and Done in cycle 4.
- Start while Busy=1 is ignored (no queueing). Start in the FINISH cycle is also ignored.
- MemAck while MemReq=0 is ignored.
- Unaligned addresses are legal; no alignment check.

Test Plan:
- Load, MemAck tied high, Address=0x000010, memory bytes 0xAB,0xCD,0xEF at 0x10..0x12 -> MemAddr sequence 0x10,0x11,0x12; Done in cycle 4; ReadData=0xABCDEF.
- Store, WriteData=0x123456 at Address=0x000020, MemAck delayed 2 cycles per byte -> MemWData 0x12,0x34,0x56 each held stable until its ack; MemWe=1 throughout; Done after 9 cycles.
- Start with MemRead=MemWrite=1 -> Error pulse; MemReq never asserts; Busy stays 0.
- Load at Address=0xFFFFFE -> MemAddr 0xFFFFFE, 0xFFFFFF, 0x000000.
- TIMEOUT_CYCLES=4, MemAck held 0 -> MemReq high 4 cycles, then Error pulse; ReadData keeps its previous value (0xABCDEF).
- Reset asserted after the first byte ack of a load -> next cycle MemReq=0, Busy=0, ReadData=0; a new Start is then accepted normally.
